fetch_queue: RTL and testbench

//  Instruction-fetch front end between the instruction memory and the decode stage of the pipelined core.

---
 rtl/fetch_queue_if.sv | 11 +
 rtl/fetch_queue.sv | 137 +++++++++++++
 tb/tb_fetch_queue.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Instruction-memory fetch bus: request/grant issue, in-order rvalid/rdata return.
interface fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_queue.sv
// Fetch front end: sequential imem requests, PC-tagged response FIFO, decode output register.
// Optional FETCH_BYPASS_EN: a response arriving on an empty FIFO goes straight to the output register.
module fetch_queue #(
  parameter logic [31:0] RESET_PC  = 32'h1000_0000,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
  input  logic                clk,
  input  logic                rst,
  fetch_queue_if.master       imem,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  input  logic                stall,
  output logic [31:0]         InstrD,
  output logic [31:0]         PCD,
  output logic                ValidD
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [1:0]    state;
  logic [31:0]   fetchAddr;
  logic [CW-1:0] outstanding, discardCnt, fifoCount, outNext;
  logic [31:0]   tagMem [DEPTH];
  logic [PW-1:0] tagWr, tagRd;
  entry_t        fifoMem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;

  logic [SW-1:0] credits;
  logic issue, rsp, keep, push, pop, bypass, fifoEmpty;
  entry_t rspEntry;

  assign credits        = {1'b0, fifoCount} + {1'b0, outstanding};
  assign imem.imem_req  = (state == RUN) && (credits < SW'(DEPTH));
  assign imem.imem_addr = fetchAddr;

  assign issue     = imem.imem_req && imem.imem_gnt;
  // rvalid with nothing outstanding is a protocol violation and is ignored
  assign rsp       = imem.imem_rvalid && (outstanding != '0);
  assign keep      = rsp && (discardCnt == '0) && !redirect;
  assign fifoEmpty = (fifoCount == '0);
`ifdef FETCH_BYPASS_EN
  assign bypass    = keep && fifoEmpty && !stall;
`else
  assign bypass    = 1'b0;
`endif
  assign push      = keep && !bypass;
  assign pop       = !redirect && !stall && !fifoEmpty;
  assign outNext   = outstanding + CW'(issue) - CW'(rsp);
  assign rspEntry  = '{pc: tagMem[tagRd], instr: imem.imem_rdata};

  // Control: FSM, fetch address, credit and discard counters, tag pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      fetchAddr   <= RESET_PC;
      outstanding <= '0;
      discardCnt  <= '0;
      tagWr       <= '0;
      tagRd       <= '0;
    end else begin
      outstanding <= outNext;
      if (issue) tagWr <= tagWr + 1'b1;
      if (rsp)   tagRd <= tagRd + 1'b1;
      if (redirect) begin
        // anything still in flight after this cycle is stale, including a same-cycle grant
        fetchAddr  <= {redirect_pc[31:2], 2'b00};
        discardCnt <= outNext;
        state      <= (state == DRAIN || outNext != '0) ? DRAIN : RUN;
      end else begin
        if (issue) fetchAddr <= fetchAddr + 32'd4;
        if (rsp && discardCnt != '0) discardCnt <= discardCnt - 1'b1;
        case (state)
          BOOT:    state <= RUN;
          DRAIN:   if (discardCnt == '0) state <= RUN;
          default: state <= state;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tagMem[tagWr] <= fetchAddr;
    if (push)  fifoMem[wrPtr] <= rspEntry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else if (redirect) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      fifoCount <= fifoCount + CW'(push) - CW'(pop);
    end
  end

  // Decode register: PCD keeps its last value across bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD <= NOP_INSTR;
      PCD    <= RESET_PC;
      ValidD <= 1'b0;
    end else if (redirect) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!stall) begin
      if (!fifoEmpty) begin
        InstrD <= fifoMem[rdPtr].instr;
        PCD    <= fifoMem[rdPtr].pc;
        ValidD <= 1'b1;
      end else if (bypass) begin
        InstrD <= rspEntry.instr;
        PCD    <= rspEntry.pc;
        ValidD <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order 1-cycle instruction memory model.
module tb_fetch_queue;
  localparam logic [31:0] RST_PC = 32'h1000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0033;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 3;
`else
  localparam int FIRST_LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic [31:0] InstrD, PCD;
  logic        ValidD;
  logic        hold = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] pendQ[$];

  fetch_queue_if bus();

  fetch_queue dut (
    .clk(clk), .rst(rst), .imem(bus), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wordOf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory: sample the issue just before the edge, answer 1 cycle later unless held
  always begin
    logic        iss;
    logic [31:0] a;
    @(negedge clk);
    #4;
    iss = bus.imem_req && bus.imem_gnt;
    a   = bus.imem_addr;
    @(posedge clk);
    #1;
    if (rst) begin
      pendQ.delete();
      bus.imem_rvalid = 1'b0;
    end else begin
      if (iss) pendQ.push_back(a);
      if (!hold && pendQ.size() != 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = wordOf(pendQ.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
      end
    end
  end

  task automatic test_reset;
    int n;
    bus.imem_gnt = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", bus.imem_req); end
    total++; if (bus.imem_addr !== RST_PC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, RST_PC); end
    total++; if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== RST_PC) begin
      bad++; $display("FAIL reset_out instr=%h valid=%b pc=%h exp %h/0/%h", InstrD, ValidD, PCD, NOP, RST_PC); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
      bad++; $display("FAIL boot_exit req=%b addr=%h exp 1/%h", bus.imem_req, bus.imem_addr, RST_PC); end
    n = 1;
    while (ValidD !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n != FIRST_LAT) begin bad++; $display("FAIL first_latency got=%0d exp=%0d", n, FIRST_LAT); end
    total++; if (ValidD !== 1'b1 || PCD !== RST_PC || InstrD !== wordOf(RST_PC)) begin
      bad++; $display("FAIL first_word valid=%b pc=%h instr=%h exp pc=%h", ValidD, PCD, InstrD, RST_PC); end
  endtask

  task automatic test_sequential;
    logic [31:0] e;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      e = RST_PC + 32'(4 * i);
      total++; if (ValidD !== 1'b1 || PCD !== e || InstrD !== wordOf(e)) begin
        bad++; $display("FAIL seq_%0d valid=%b pc=%h instr=%h exp pc=%h", i, ValidD, PCD, InstrD, e); end
    end
  endtask

  task automatic test_stall;
    logic [31:0] held, e;
    held = 32'h1000_001C;
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (ValidD !== 1'b1 || PCD !== held || InstrD !== wordOf(held)) begin
        bad++; $display("FAIL stall_hold_%0d valid=%b pc=%h exp pc=%h", i, ValidD, PCD, held); end
    end
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_credit req=%b exp=0", bus.imem_req); end
    stall = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      e = held + 32'(4 * i);
      total++; if (ValidD !== 1'b1 || PCD !== e || InstrD !== wordOf(e)) begin
        bad++; $display("FAIL stall_release_%0d valid=%b pc=%h exp pc=%h", i, ValidD, PCD, e); end
    end
  endtask

  task automatic test_redirect_drain;
    int n;
    bus.imem_gnt = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (ValidD !== 1'b0 || InstrD !== NOP) begin
      bad++; $display("FAIL idle_bubble valid=%b instr=%h exp 0/%h", ValidD, InstrD, NOP); end
    hold = 1'b1;
    bus.imem_gnt = 1'b1;
    repeat (2) @(negedge clk);
    bus.imem_gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h1000_0102;
    @(negedge clk);
    redirect = 1'b0;
    total++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h1000_0100) begin
      bad++; $display("FAIL drain_enter req=%b addr=%h exp 0/10000100", bus.imem_req, bus.imem_addr); end
    total++; if (ValidD !== 1'b0 || InstrD !== NOP) begin
      bad++; $display("FAIL drain_flush valid=%b instr=%h exp 0/%h", ValidD, InstrD, NOP); end
    hold = 1'b0;
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL drain_hold req=%b exp=0", bus.imem_req); end
    n = 0;
    while (ValidD !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (ValidD !== 1'b1 || PCD !== 32'h1000_0100 || InstrD !== wordOf(32'h1000_0100)) begin
      bad++; $display("FAIL drain_target valid=%b pc=%h instr=%h exp pc=10000100", ValidD, PCD, InstrD); end
  endtask

  task automatic test_redirect_same_cycle;
    int n;
    repeat (6) @(negedge clk);
    total++; if (bus.imem_req !== 1'b1 || bus.imem_rvalid !== 1'b1) begin
      bad++; $display("FAIL same_cycle_setup req=%b rvalid=%b exp 1/1", bus.imem_req, bus.imem_rvalid); end
    redirect = 1'b1;
    redirect_pc = 32'h1000_0200;
    @(negedge clk);
    redirect = 1'b0;
    total++; if (bus.imem_req !== 1'b0 || ValidD !== 1'b0) begin
      bad++; $display("FAIL same_cycle_drain req=%b valid=%b exp 0/0", bus.imem_req, ValidD); end
    n = 0;
    while (ValidD !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (ValidD !== 1'b1 || PCD !== 32'h1000_0200 || InstrD !== wordOf(32'h1000_0200)) begin
      bad++; $display("FAIL same_cycle_target valid=%b pc=%h exp pc=10000200", ValidD, PCD); end
    @(negedge clk);
    total++; if (ValidD !== 1'b1 || PCD !== 32'h1000_0204) begin
      bad++; $display("FAIL same_cycle_next valid=%b pc=%h exp pc=10000204", ValidD, PCD); end
  endtask

  task automatic test_wrap;
    int n;
    logic [31:0] e;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    n = 0;
    while (ValidD !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    e = 32'hFFFF_FFF8;
    for (int i = 0; i < 4; i++) begin
      total++; if (ValidD !== 1'b1 || PCD !== e || InstrD !== wordOf(e)) begin
        bad++; $display("FAIL wrap_%0d valid=%b pc=%h exp pc=%h", i, ValidD, PCD, e); end
      e = e + 32'd4;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== RST_PC) begin
      bad++; $display("FAIL midreset_out instr=%h valid=%b pc=%h exp %h/0/%h", InstrD, ValidD, PCD, NOP, RST_PC); end
    total++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== RST_PC) begin
      bad++; $display("FAIL midreset_bus req=%b addr=%h exp 0/%h", bus.imem_req, bus.imem_addr, RST_PC); end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (ValidD !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (ValidD !== 1'b1 || PCD !== RST_PC || InstrD !== wordOf(RST_PC)) begin
      bad++; $display("FAIL midreset_refetch valid=%b pc=%h exp pc=%h", ValidD, PCD, RST_PC); end
    @(negedge clk);
    total++; if (ValidD !== 1'b1 || PCD !== RST_PC + 32'd4) begin
      bad++; $display("FAIL midreset_next valid=%b pc=%h exp pc=%h", ValidD, PCD, RST_PC + 32'd4); end
  endtask

  initial begin
    bus.imem_gnt = 1'b0;
    test_reset;
    test_sequential;
    test_stall;
    test_redirect_drain;
    test_redirect_same_cycle;
    test_wrap;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
